// File: rtl/sram_bist_seq_pkg.sv
// dlx_bist_pkg: shared types and helpers for the SRAM self-test sequencer.
//   state_t    - sequencer FSM states
//   PASS_NIB / FAIL_NIB - leading nibble of the display word in DONE
//   pat()      - test pattern for an address and pass index
//   busy_word() / done_word() - display word builders
package dlx_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_GAP,
    S_RD,
    S_RD_WAIT,
    S_CMP,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [3:0] PASS_NIB = 4'hA;
  localparam logic [3:0] FAIL_NIB = 4'hE;

  // Address plus one, inverted on the second pass; callers truncate to their
  // data width.
  function automatic logic [63:0] pat(input logic [63:0] a, input logic p);
    logic [63:0] v;
    v = a + 64'd1;
    return p ? ~v : v;
  endfunction

  function automatic logic [31:0] busy_word(input logic p, input logic [19:0] a);
    return {3'b000, p, 8'h00, a};
  endfunction

  function automatic logic [31:0] done_word(input logic ok, input logic [15:0] e);
    return {(ok ? PASS_NIB : FAIL_NIB), 12'h000, e};
  endfunction

endpackage

// File: rtl/sram_bist_chk.sv
// sram_bist_chk: read-back comparator with saturating error counter and
// first-error address latch.
//   clk_div8, rst_n  - clock, async active-low reset
//   clear            - synchronous clear of count, latch and seen flag
//   sample           - compare rd_data against exp_data at this edge
//   addr             - address of the word being compared
//   exp_data/rd_data - expected / returned data
//   err_count        - saturating mismatch count
//   first_err_addr   - address of the first mismatch since clear
module sram_bist_chk import dlx_bist_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk_div8,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  sample,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  logic seen;

  always_ff @(posedge clk_div8 or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
    end else if (clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
    end else if (sample && (rd_data != exp_data)) begin
      if (err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
      if (!seen) begin
        seen           <= 1'b1;
        first_err_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/sram_bist_seq.sv
// sram_bist_seq: SRAM self-test sequencer feeding sram_ctrl.
// Writes pat(addr,p) over START_ADDR..END_ADDR, reads it back and compares,
// for p = 0 then p = 1, then reports in DONE.
//   clk_div8, rst_n   - block clock, async active-low reset
//   start             - level, sampled in IDLE/DONE only
//   mem_wr_en/rd_en   - single-cycle strobes to sram_ctrl
//   mem_addr          - address to sram_ctrl
//   mem_wr_data       - write data (0 during read phase)
//   mem_rd_data       - read data from sram_ctrl
//   busy/done/pass    - run status
//   err_count         - saturating mismatch count
//   first_err_addr    - address of first mismatch
//   status_o          - 32-bit display word
module sram_bist_seq import dlx_bist_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 'h3FC,
  parameter int STEP       = 4,
  parameter int GAP        = 3,
  parameter int RD_LATENCY = 1,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk_div8,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [31:0]           status_o
);

  localparam int CNT_MAX = (GAP > RD_LATENCY) ? GAP : RD_LATENCY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(STEP);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic                  p;
  logic [CNT_W-1:0]      cnt;
  logic                  start_ok;
  logic                  sample;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  no_err;

  always_comb begin
    addr_step = addr + STEP_A;
    start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    sample    = (state == S_CMP);
    exp_data  = DATA_WIDTH'(pat(64'(addr), p));
    no_err    = (err_count == '0);
  end

  sram_bist_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ERR_WIDTH  (ERR_WIDTH)
  ) u_chk (
    .clk_div8       (clk_div8),
    .rst_n          (rst_n),
    .clear          (start_ok),
    .sample         (sample),
    .addr           (addr),
    .exp_data       (exp_data),
    .rd_data        (mem_rd_data),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  // Outputs are registered alongside the state, so each branch loads the
  // values that belong to the state it is entering.
  always_ff @(posedge clk_div8 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      p           <= 1'b0;
      cnt         <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      status_o    <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_WR;
            addr        <= START_A;
            p           <= 1'b0;
            mem_wr_en   <= 1'b1;
            mem_addr    <= START_A;
            mem_wr_data <= DATA_WIDTH'(pat(64'(START_A), 1'b0));
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            status_o    <= busy_word(1'b0, 20'(START_A));
          end
        end
        S_WR: begin
          state <= S_WR_GAP;
          cnt   <= CNT_W'(GAP - 1);
        end
        S_WR_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (addr == END_A) begin
            state       <= S_RD;
            addr        <= START_A;
            mem_rd_en   <= 1'b1;
            mem_addr    <= START_A;
            mem_wr_data <= '0;
            status_o    <= busy_word(p, 20'(START_A));
          end else begin
            state       <= S_WR;
            addr        <= addr_step;
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_step;
            mem_wr_data <= DATA_WIDTH'(pat(64'(addr_step), p));
            status_o    <= busy_word(p, 20'(addr_step));
          end
        end
        S_RD: begin
          if (RD_LATENCY == 1) begin
            state <= S_CMP;
          end else begin
            state <= S_RD_WAIT;
            cnt   <= CNT_W'(RD_LATENCY - 2);
          end
        end
        S_RD_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= S_CMP;
        end
        S_CMP: begin
          if (addr == END_A) begin
            state <= S_NEXT;
          end else begin
            state     <= S_RD;
            addr      <= addr_step;
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_step;
            status_o  <= busy_word(p, 20'(addr_step));
          end
        end
        S_NEXT: begin
          if (!p) begin
            state       <= S_WR;
            p           <= 1'b1;
            addr        <= START_A;
            mem_wr_en   <= 1'b1;
            mem_addr    <= START_A;
            mem_wr_data <= DATA_WIDTH'(pat(64'(START_A), 1'b1));
            status_o    <= busy_word(1'b1, 20'(START_A));
          end else begin
            // err_count already holds the last compare of pass 1 here.
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= no_err;
            status_o <= done_word(no_err, 16'(err_count));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
